// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and hex-to-segment table for the seven-segment scan controller.
// Pure combinational helpers: no latency, no flow control.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

    // Segment order {a,b,c,d,e,f,g}, active-high
    function automatic logic [6:0] seg7_enc(input logic [3:0] hex);
        logic [6:0] s;
        s = 7'b0000000;
        case (hex)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-update handshake: sender offers a full hex/dp word, controller raises ready when its buffer is empty.
// Transfer on upd_valid & upd_ready; sender holds the word while ready is low.
interface seg7_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic                 upd_valid;
    logic                 upd_ready;
    logic [4*NDIG-1:0]    upd_hex;
    logic [NDIG-1:0]      upd_dp;

    modport master (output upd_valid, output upd_hex, output upd_dp, input upd_ready);
    modport slave  (input upd_valid, input upd_hex, input upd_dp, output upd_ready);
endinterface

// File: rtl/seg7_slot_timer.sv
// Loadable down-counter; done is high combinationally while the count is zero, so a load of N-1 yields an N-cycle slot.
// No backpressure: load wins over counting.
module seg7_slot_timer #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= RST_VAL;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner: BLANK gap then DRIVE slot per digit; one-word pending buffer committed at frame end.
// Outputs registered (change with state); ready drops while a word is pending. SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_ctrl_if.slave   upd,
    output logic [NDIG-1:0]   an,
    output logic [7:0]        seg,
    output logic              frame_tick
);
    localparam int TMAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYC - 1);
    localparam logic [TW-1:0] DRIVE_LD = TW'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NDIG-1:0][3:0]   act_hex_q, act_hex_d, pend_hex_q, pend_hex_d;
    logic [NDIG-1:0]        act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                   pend_full_q, pend_full_d;
    logic [NDIG-1:0]        an_q, an_d;
    logic [7:0]             seg_q, seg_d;
    logic                   tick_q, tick_d;
    logic                   tmr_done;
    logic [TW-1:0]          tmr_ld_val;
    logic [NDIG-1:0]        lz_blank;
    logic                   accept;

    seg7_slot_timer #(.W(TW), .RST_VAL(BLANK_LD)) u_tmr (
        .clk      (clk),
        .rst_n    (reset),
        .load     (tmr_done),
        .load_val (tmr_ld_val),
        .done     (tmr_done)
    );

`ifdef SEG7_LZB_EN
    // A digit is blank when it and every more-significant digit are zero and its own point is off
    always_comb begin
        logic [4*NDIG-1:0] hex_flat;
        hex_flat = act_hex_q;
        lz_blank = '0;
        for (int i = 1; i < NDIG; i++) begin
            lz_blank[i] = ((hex_flat >> (4 * i)) == '0) && !act_dp_q[i];
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign accept        = upd.upd_valid && !pend_full_q;
    assign upd.upd_ready = !pend_full_q;
    assign an            = an_q;
    assign seg           = seg_q;
    assign frame_tick    = tick_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        act_hex_d   = act_hex_q;
        act_dp_d    = act_dp_q;
        pend_hex_d  = pend_hex_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        tick_d      = 1'b0;
        tmr_ld_val  = BLANK_LD;
        an_d        = AN_OFF[NDIG-1:0];
        seg_d       = SEG_OFF;

        if (accept) begin
            pend_hex_d  = upd.upd_hex;
            pend_dp_d   = upd.upd_dp;
            pend_full_d = 1'b1;
        end

        if (tmr_done) begin
            if (state_q == ST_BLANK) begin
                state_d    = ST_DRIVE;
                tmr_ld_val = DRIVE_LD;
            end else begin
                state_d = ST_BLANK;
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                // Frame boundary: accept cannot fire here since it needs the buffer empty
                if (idx_q == LAST_IDX) begin
                    tick_d = 1'b1;
                    if (pend_full_q) begin
                        act_hex_d   = pend_hex_q;
                        act_dp_d    = pend_dp_q;
                        pend_full_d = 1'b0;
                    end
                end
            end
        end

        if (state_d == ST_DRIVE && !lz_blank[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = {seg7_enc(act_hex_q[idx_d]), act_dp_q[idx_d]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BLANK;
            idx_q       <= '0;
            act_hex_q   <= '0;
            act_dp_q    <= '0;
            pend_hex_q  <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            an_q        <= AN_OFF[NDIG-1:0];
            seg_q       <= SEG_OFF;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            act_hex_q   <= act_hex_d;
            act_dp_q    <= act_dp_d;
            pend_hex_q  <= pend_hex_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            tick_q      <= tick_d;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIG=4, CLK_DIV=8, BLANK_CYC=2 (40-cycle frame); outputs sampled on falling edges.
module tb_seg7_scan_ctrl;
    localparam int NDIG      = 4;
    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int SLOT      = CLK_DIV + BLANK_CYC;
    localparam int FRAME     = NDIG * SLOT;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NDIG-1:0]  an;
    logic [7:0]       seg;
    logic             frame_tick;

    seg7_scan_ctrl_if #(.NDIG(NDIG)) upd_if ();

    seg7_scan_ctrl #(.NDIG(NDIG), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .upd        (upd_if.slave),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0]      hex;
        logic [3:0]       dp;
        logic [3:0][7:0]  segs;   // expected seg per digit, [3]=digit3
        logic [3:0]       lzb;    // digits blanked when leading-zero blanking is built in
    } vec_t;

    vec_t vecs[6];

    localparam logic [31:0] ZERO_SEGS = {4{8'b11111100}};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] lzb_mask(input logic [3:0] m);
`ifdef SEG7_LZB_EN
        return m;
`else
        return 4'b0000 & m;
`endif
    endfunction

    // Starts sampling at the current falling edge, which must be the first BLANK cycle of digit 0
    task automatic check_frame(input logic [31:0] segs_flat, input logic [3:0] blank,
                               input logic tick0, input string nm);
        logic [3:0][7:0] segs;
        logic [3:0]      exp_an;
        logic [7:0]      exp_seg;
        int              slot;
        bit              drive;
        segs = segs_flat;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            slot    = c / SLOT;
            drive   = ((c % SLOT) >= BLANK_CYC) && !blank[slot];
            exp_an  = 4'hF;
            exp_seg = 8'h00;
            if (drive) begin
                exp_an[slot] = 1'b0;
                exp_seg      = segs[slot];
            end
            chk($sformatf("%s an c%0d", nm, c), 32'(an), 32'(exp_an));
            chk($sformatf("%s seg c%0d", nm, c), 32'(seg), 32'(exp_seg));
            chk($sformatf("%s tick c%0d", nm, c), 32'(frame_tick), (c == 0) ? 32'(tick0) : 32'd0);
        end
    endtask

    task automatic wait_tick(input string nm, output int early_ready);
        bit ok;
        ok = 1'b0;
        early_ready = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
            if (upd_if.upd_ready) early_ready++;
        end
        chk({nm, " tick seen"}, 32'(ok), 32'd1);
    endtask

    initial begin
        int early;
        vecs[0] = '{16'h1A3F, 4'b0010, {8'b01100000, 8'b11101110, 8'b11110011, 8'b10001110}, 4'b0000};
        vecs[1] = '{16'hFFFF, 4'b0000, {4{8'b10001110}},                                     4'b0000};
        vecs[2] = '{16'h8642, 4'b0000, {8'b11111110, 8'b10111110, 8'b01100110, 8'b11011010}, 4'b0000};
        vecs[3] = '{16'hBCDE, 4'b1111, {8'b00111111, 8'b10011101, 8'b01111011, 8'b10011111}, 4'b0000};
        vecs[4] = '{16'h5790, 4'b0101, {8'b10110110, 8'b11100001, 8'b11110110, 8'b11111101}, 4'b0000};
        vecs[5] = '{16'h0050, 4'b0000, {8'b11111100, 8'b11111100, 8'b10110110, 8'b11111100}, 4'b1100};

        upd_if.upd_valid = 1'b0;
        upd_if.upd_hex   = '0;
        upd_if.upd_dp    = '0;

        repeat (3) @(negedge clk);
        chk("reset an", 32'(an), 32'hF);
        chk("reset seg", 32'(seg), 32'h0);
        chk("reset tick", 32'(frame_tick), 32'h0);
        chk("reset ready", 32'(upd_if.upd_ready), 32'h1);

        reset = 1'b1;
        check_frame(ZERO_SEGS, lzb_mask(4'b1110), 1'b0, "first frame");
        @(negedge clk);
        chk("tick after 40", 32'(frame_tick), 32'h1);
        chk("ready idle", 32'(upd_if.upd_ready), 32'h1);

        // Each word accepted mid-frame, committed at the next boundary, shown in the frame after it
        for (int i = 0; i < 6; i++) begin
            repeat (5) @(negedge clk);
            chk($sformatf("v%0d ready before", i), 32'(upd_if.upd_ready), 32'h1);
            upd_if.upd_valid = 1'b1;
            upd_if.upd_hex   = vecs[i].hex;
            upd_if.upd_dp    = vecs[i].dp;
            @(negedge clk);
            upd_if.upd_valid = 1'b0;
            chk($sformatf("v%0d ready after", i), 32'(upd_if.upd_ready), 32'h0);
            if (i == 0) begin
                upd_if.upd_valid = 1'b1;
                upd_if.upd_hex   = 16'hFFFF;
                upd_if.upd_dp    = 4'b0000;
                repeat (3) begin
                    @(negedge clk);
                    chk("ignored offer ready", 32'(upd_if.upd_ready), 32'h0);
                end
                upd_if.upd_valid = 1'b0;
            end
            wait_tick($sformatf("v%0d", i), early);
            chk($sformatf("v%0d ready held low", i), 32'(early), 32'd0);
            chk($sformatf("v%0d ready at commit", i), 32'(upd_if.upd_ready), 32'h1);
            check_frame(vecs[i].segs, lzb_mask(vecs[i].lzb), 1'b1, $sformatf("v%0d", i));
            @(negedge clk);
            chk($sformatf("v%0d next tick", i), 32'(frame_tick), 32'h1);
        end

        // Offer lands on the commit edge itself: accepted, but the display waits a whole frame
        repeat (FRAME - 1) @(negedge clk);
        chk("commit-cycle ready", 32'(upd_if.upd_ready), 32'h1);
        upd_if.upd_valid = 1'b1;
        upd_if.upd_hex   = 16'h4321;
        upd_if.upd_dp    = 4'b1000;
        @(negedge clk);
        upd_if.upd_valid = 1'b0;
        chk("commit-cycle accepted", 32'(upd_if.upd_ready), 32'h0);
        check_frame(vecs[5].segs, lzb_mask(vecs[5].lzb), 1'b1, "old value held");
        @(negedge clk);
        check_frame({8'b01100111, 8'b11110010, 8'b11011010, 8'b01100000}, 4'b0000, 1'b1, "4321 shown");

        // Reset mid digit-2 drive with a word pending; the pending word must be lost
        @(negedge clk);
        repeat (5) @(negedge clk);
        upd_if.upd_valid = 1'b1;
        upd_if.upd_hex   = 16'h2222;
        upd_if.upd_dp    = 4'b0000;
        @(negedge clk);
        upd_if.upd_valid = 1'b0;
        chk("pending before reset", 32'(upd_if.upd_ready), 32'h0);
        repeat (2 * SLOT + BLANK_CYC + 3 - 6) @(negedge clk);
        chk("digit2 driving", 32'(an), 32'hB);
        reset = 1'b0;
        #1;
        chk("async rst an", 32'(an), 32'hF);
        chk("async rst seg", 32'(seg), 32'h0);
        chk("async rst ready", 32'(upd_if.upd_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_frame(ZERO_SEGS, lzb_mask(4'b1110), 1'b0, "post reset");
        @(negedge clk);
        check_frame(ZERO_SEGS, lzb_mask(4'b1110), 1'b1, "pending discarded");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
